// File: rtl/fact_accel_mm.sv
// fact_accel_mm
// -------------
// Memory-mapped factorial accelerator. Software writes an operand n, issues a
// go command, then polls STATUS until done is set and reads RESULT.
//
// Register map (word addressed):
//   a=0  N      : RW, write latches wd[3:0], reads {28'b0, n}
//   a=1  GO     : write wd[0]=1 requests a computation, reads {31'b0, go_r}
//   a=2  STATUS : RO, reads {30'b0, err, done}
//   a=3  RESULT : RO, reads the last 32-bit result
//
// Bus handshake: there is no valid/ready pair on this port. A write happens
// on every rising edge where we=1. A read is a pure combinational decode of
// a, so it returns the value that the registers hold before the edge.
//
// Ports:
//   clk       system clock, rising-edge active
//   rst       asynchronous, active-low reset
//   we        write enable for the addressed register
//   a[1:0]    word address
//   wd[31:0]  write data
//   rd[31:0]  combinational read data
//   done      STATUS[0], brought out as a pin for GPIO mirroring
//   err       STATUS[1], brought out as a pin for GPIO mirroring
//   state_dbg current FSM state (0 = IDLE, 1 = BUSY), for observation only
module fact_accel_mm #(
    parameter int N_MAX = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        done,
    output logic        err,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] N_MAX_4 = 4'(N_MAX);

    state_t      state, state_n;
    logic [3:0]  n, n_n;
    logic        go_r, go_n;
    logic        done_r, done_n;
    logic        err_r, err_n;
    logic [31:0] result, result_n;
    logic [31:0] prod, prod_n;
    logic [3:0]  cnt, cnt_n;
    logic        go_accept;

    // A go is taken only when the block is idle and has no request pending,
    // so a go written during a computation can never restart it.
    assign go_accept = we && (a == 2'd1) && wd[0] && (state == IDLE) && !go_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            n      <= 4'd0;
            go_r   <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            result <= 32'd0;
            prod   <= 32'd0;
            cnt    <= 4'd0;
        end else begin
            state  <= state_n;
            n      <= n_n;
            go_r   <= go_n;
            done_r <= done_n;
            err_r  <= err_n;
            result <= result_n;
            prod   <= prod_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        n_n      = n;
        go_n     = go_r;
        done_n   = done_r;
        err_n    = err_r;
        result_n = result;
        prod_n   = prod;
        cnt_n    = cnt;

        // N may be rewritten at any time; a running computation keeps
        // working from its own copy in cnt.
        if (we && (a == 2'd0)) begin
            n_n = wd[3:0];
        end

        case (state)
            IDLE: begin
                if (go_r) begin
                    if (n > N_MAX_4) begin
                        // 13! and above overflow 32 bits: report and stay idle.
                        err_n    = 1'b1;
                        done_n   = 1'b1;
                        result_n = 32'd0;
                        go_n     = 1'b0;
                    end else begin
                        prod_n  = 32'd1;
                        cnt_n   = n;
                        state_n = BUSY;
                    end
                end else if (go_accept) begin
                    go_n   = 1'b1;
                    done_n = 1'b0;
                    err_n  = 1'b0;
                end
            end
            BUSY: begin
                // cnt<=1 covers both 0! and 1!, which leave prod at 1.
                if (cnt <= 4'd1) begin
                    result_n = prod;
                    done_n   = 1'b1;
                    go_n     = 1'b0;
                    state_n  = IDLE;
                end else begin
                    prod_n = prod * {28'd0, cnt};
                    cnt_n  = cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        rd = 32'd0;
        case (a)
            2'd0: rd = {28'd0, n};
            2'd1: rd = {31'd0, go_r};
            2'd2: rd = {30'd0, err_r, done_r};
            2'd3: rd = result;
            default: rd = 32'd0;
        endcase
    end

    assign done      = done_r;
    assign err       = err_r;
    assign state_dbg = state;

endmodule

// File: doc/fact_accel_mm.md
# fact_accel_mm

Memory-mapped factorial accelerator: the bus-side responder that the single-cycle CPU's driver code polls. It latches an operand n, computes n! with an iterative multiply FSM on a go command, and exposes done, error and result registers over a word-addressed read/write port. It sits on the system bus beside the GPIO block. Its `done`/`err` flags are also brought out as pins so that GPIO (`gpO1[1:0]`) can mirror them.

## Interface
- `N_MAX`, 12: largest n accepted; any larger value sets `err` (13! overflows 32 bits).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `we`  in  1  write enable for the addressed register.
- `a`  in  2  word address (0 = N, 1 = GO, 2 = STATUS, 3 = RESULT).
- `wd`  in  32  write data.
- `rd`  out  32  read data; combinational decode of `a`.
- `done`  out  1  copy of STATUS[0].
- `err`  out  1  copy of STATUS[1].

## Operation
- Register map, with read values:
  - A=0, N: write latches `wd[3:0]`; reads `{28'b0, n}`.
  - A=1, GO: write with `wd[0]=1` sets `go_r` if the block is accepting (see below); reads `{31'b0, go_r}`.
  - A=2, STATUS: read-only; reads `{30'b0, err, done}`.
  - A=3, RESULT: read-only; reads the 32-bit result.
  - Writes to A=2 and A=3 are ignored.
- FSM states: IDLE and BUSY.
- IDLE:
  - If `go_r=1` and `n>N_MAX`: set `err=1`, `done=1`, `result=0`, `go_r=0`; stay in IDLE.
  - If `go_r=1` and `n<=N_MAX`: load `prod=1` and `cnt=n`, then go to BUSY.
- BUSY, each cycle:
  - If `cnt<=1`: set `result=prod`, `done=1`, `go_r=0`, and return to IDLE.
  - Otherwise: `prod <= prod*cnt` (truncated to 32 bits), `cnt <= cnt-1`.
- Accepting a go: a go write is accepted only when state=IDLE and `go_r=0`. An accepted go sets `go_r=1` and clears `done` and `err` on the same edge. `result` holds its old value until the new result is written.
- Go writes while BUSY, or while `go_r=1`, are ignored. They never restart the computation.
- Writes to N while BUSY update `n` only. The running computation uses the latched `cnt`.
- A GO write with `wd[0]=0` has no effect.
- Arithmetic: `prod` is 32 bits and `cnt` is 4 bits. For n≤12 the product never exceeds 32 bits. Results: 0! = 1 and 1! = 1.
- Reset (`rst=0`, at any time, including mid-computation):
  - Values: `n=0`, `go_r=0`, `done=0`, `err=0`, `result=0`, `prod=0`, `cnt=0`, state=IDLE.
  - Any computation in flight is abandoned.
  - `rd` reflects the reset values immediately.

## Timing
- Edge numbering: E0 is the edge that captures an accepted go write; E1, E2, … are the following edges.
- E1: IDLE consumes `go_r`.
  - Error case: `done=1` and `err=1` are visible after E1.
  - Valid n: the FSM enters BUSY.
- BUSY lasts max(n,1) cycles. `done=1` and a valid `result` appear after edge E(1+max(n,1)).
  - n=5: 6 edges after E0.
  - n=0 or n=1: 2 edges after E0.
  - n=12: 13 edges after E0.
- `done` and `result` update on the same edge. They are never observed out of step.
- `rd` is combinational with zero latency. A read in the same cycle as a write returns the pre-edge value.
- Back-to-back: a go write on the edge that sets `done` is rejected, because `go_r` is still 1 until that edge. The earliest accepted re-go is on the next edge.
- Outputs are registered, except `rd`.

## Test plan
- Reset: hold `rst=0` for 2 cycles, then read A=0..3 → all reads 0; `done=0` and `err=0`.
- n=5: write A0=5, then A1=1 → `done` rises exactly 6 edges after the go edge; A3 reads 120; STATUS reads 0x1.
- n=0 then n=12: n=0 → A3 reads 1 after 2 edges. n=12 → A3 reads 479001600 (0x1C8CFC00) after 13 edges; `err=0` in both cases.
- n=13: write A0=13, then go → after 1 edge STATUS reads 0x3 and A3 reads 0; a subsequent go with n=4 clears `err` and yields 24.
- Go and N writes while busy: start n=6, write A0=2 and A1=1 during BUSY → result 720 after 7 edges; `n` now reads 2; the next go yields 2.
- Reset mid-computation: start n=10, assert `rst` after 4 cycles → all registers 0 and state IDLE; after release, go with n=3 yields 6.
